mean_frame_tx: RTL and testbench
================================

# mean_frame_tx

Frame transmitter for the mean filter's sample input. It buffers Q1.15 samples from an upstream ready/valid source in a small FIFO. On `start`, it emits exactly FRAME_LEN samples on the valid/data stream that feeds the `mean` block. It then waits for the mean block's result-valid before it accepts another frame, so one frame is always paired with one mean result.

## Interface
- DATA_W, 16, sample width (Q1.15)
- FRAME_LEN, 2048, samples per frame (≥2)
- FIFO_DEPTH, 16, buffer entries (power of 2, ≥2)
- TIMEOUT, 64, max cycles in WAIT_RES before abort (≥1)

- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- s_valid  in  1  upstream sample valid
- s_ready  out  1  upstream ready, = FIFO not full
- s_data  in  DATA_W  upstream sample
- start  in  1  begin-frame request, sampled only in IDLE
- valid_out  out  1  to mean `valid_in`
- data_out  out  DATA_W  to mean `data_in`
- mean_valid  in  1  from mean `valid_out` (result ready)
- busy  out  1  high in SEND or WAIT_RES
- frame_done  out  1  one-cycle pulse on result received
- timeout  out  1  one-cycle pulse on WAIT_RES abort
- stalled  out  1  high in SEND while FIFO empty

## Operation
- FIFO:
  - Push when s_valid && s_ready, in any state.
  - s_ready = !full, combinational from count. There is no pop-through when full.
  - No bypass: a word pushed in cycle N is poppable at N+1 at the earliest.
  - Push and pop in the same cycle: count unchanged.
- FSM states: IDLE, SEND, WAIT_RES.
- IDLE:
  - start=1 → SEND, and the sample counter clears to 0.
  - Any other input is ignored.
- SEND:
  - A cycle with FIFO non-empty pops the head, captures it into data_out, sets valid_out=1 on the next edge, and increments the counter.
  - A cycle with FIFO empty: no pop, valid_out=0 next edge, stalled=1. The frame resumes when data arrives; gaps are legal on the mean input.
  - The pop that makes count = FRAME_LEN moves the FSM to WAIT_RES.
  - mean_valid is ignored in SEND.
- WAIT_RES:
  - valid_out=0.
  - mean_valid=1 → frame_done pulse, then IDLE.
  - Otherwise the wait counter increments. Reaching TIMEOUT gives a timeout pulse, then IDLE.
  - mean_valid and the timeout terminal count in the same cycle: mean_valid wins, giving frame_done only.
- start while busy is ignored and not queued.
- Samples are forwarded bit-exact. No arithmetic on data.
- Counter widths are $clog2(FRAME_LEN+1) and $clog2(TIMEOUT+1).

## Timing
- Reset values:
  - State IDLE, FIFO empty, both counters 0.
  - Outputs: valid_out=0, data_out=0, busy=0, frame_done=0, timeout=0, stalled=0.
  - s_ready=1 in the cycle after reset.
- Reset mid-frame: the FIFO is flushed, partial frame discarded, and valid_out=0 from the next edge.
- Latency:
  - start sampled at edge N → busy=1 after edge N.
  - First pop at edge N+1; first valid_out=1 after edge N+1 (FIFO non-empty).
- Throughput: one sample per cycle while the FIFO stays non-empty. A full frame with no stalls takes FRAME_LEN consecutive valid_out cycles.
- The last valid_out and the WAIT_RES entry occur on the same edge.
- frame_done and timeout are registered and one cycle wide.
- busy falls on the same edge they rise.
- valid_out, data_out, busy, frame_done and timeout are registered. s_ready and stalled are derived from registered state.

## Test plan
- **Reset:** hold rst=1 for 3 cycles with s_valid=1 and start=1.
  - All outputs stay at reset values and s_ready=1.
  - No push occurs: the FIFO is empty after release.
- **Full frame:** source 0x4000 continuously, pulse start, mean model asserts mean_valid 5 cycles after the last sample.
  - Exactly 2048 valid_out cycles, each with data_out=0x4000.
  - One frame_done pulse, then busy=0.
  - Mean output = 0x4000.
- **Stalls:** source delivers 0xC000 with s_valid on every third cycle.
  - stalled=1 in the gap cycles and valid_out=0 there.
  - The total valid count is still 2048 and the data order is preserved.
- **Backpressure:** preload 20 words 0x0001..0x0014 in IDLE with FIFO_DEPTH=16.
  - s_ready drops after 16 pushes and the source holds 0x0011.
  - After start, output order is 0x0001..0x0014 with no loss or duplication.
- **Timeout:** complete a frame with mean_valid never asserted.
  - A timeout pulse occurs 64 cycles after WAIT_RES entry, frame_done never asserts, and the FSM returns to IDLE.
  - A second start then runs normally.
- **Corner cases:**
  - start pulsed during SEND is ignored, giving exactly 2048 samples.
  - mean_valid in SEND gives no frame_done.
  - rst asserted at sample 1000 drops valid_out next cycle and empties the FIFO.
  - mean_valid coincident with the timeout terminal count gives frame_done only.

Source files
------------

// File: rtl/mean_frame_tx.sv
// mean_frame_tx: buffers upstream Q1.15 samples in a small FIFO and, on start,
// streams exactly FRAME_LEN of them to the mean block, then waits (bounded by
// TIMEOUT cycles) for the mean result before accepting another frame.
module mean_frame_tx #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned FRAME_LEN  = 2048,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned TIMEOUT    = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              start,
    output logic              valid_out,
    output logic [DATA_W-1:0] data_out,
    input  logic              mean_valid,
    output logic              busy,
    output logic              frame_done,
    output logic              timeout,
    output logic              stalled
);

    localparam int unsigned AW    = $clog2(FIFO_DEPTH);
    localparam int unsigned CW    = AW + 1;
    localparam int unsigned CNT_W = $clog2(FRAME_LEN + 1);
    localparam int unsigned TO_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2
    } state_e;

    // FIFO storage and bookkeeping
    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              push, pop, fifo_empty, fifo_full;

    // FSM and counters
    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [TO_W-1:0]   wait_q, wait_d;

    // Registered outputs
    logic              valid_out_q, valid_out_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              busy_q, busy_d;
    logic              frame_done_q, frame_done_d;
    logic              timeout_q, timeout_d;

    // FIFO status flags, handshake and pop qualification
    assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign s_ready    = !fifo_full;
    assign push       = s_valid && !fifo_full;
    assign pop        = (state_q == ST_SEND) && !fifo_empty;
    assign stalled    = (state_q == ST_SEND) && fifo_empty;

    // FIFO pointer and occupancy next-state
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO data array: written on accepted pushes, never while in reset
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem_q[wr_ptr_q] <= s_data;
        end
    end

    // FSM next-state, counters and output next-values
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        wait_d       = wait_q;
        valid_out_d  = 1'b0;
        data_out_d   = data_out_q;
        frame_done_d = 1'b0;
        timeout_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SEND;
                    cnt_d   = '0;
                end
            end
            ST_SEND: begin
                if (!fifo_empty) begin
                    valid_out_d = 1'b1;
                    data_out_d  = mem_q[rd_ptr_q];
                    cnt_d       = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(FRAME_LEN - 1)) begin
                        state_d = ST_WAIT;
                        wait_d  = '0;
                    end
                end
            end
            ST_WAIT: begin
                // A result arriving on the terminal-count cycle still counts as done
                if (mean_valid) begin
                    frame_done_d = 1'b1;
                    state_d      = ST_IDLE;
                end else if (wait_q == TO_W'(TIMEOUT - 1)) begin
                    timeout_d = 1'b1;
                    wait_d    = wait_q + TO_W'(1);
                    state_d   = ST_IDLE;
                end else begin
                    wait_d = wait_q + TO_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State, counter, FIFO-pointer and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            wait_q       <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            valid_out_q  <= 1'b0;
            data_out_q   <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            wait_q       <= wait_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            valid_out_q  <= valid_out_d;
            data_out_q   <= data_out_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            timeout_q    <= timeout_d;
        end
    end

    assign valid_out  = valid_out_q;
    assign data_out   = data_out_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign timeout    = timeout_q;

endmodule

// File: tb/tb_mean_frame_tx.sv
// Directed bench for mean_frame_tx: queue-driven source, simple mean-result
// model, per-cycle monitor; each scenario task checks its own expectations.
module tb_mean_frame_tx;

    localparam int DATA_W     = 16;
    localparam int FRAME_LEN  = 2048;
    localparam int FIFO_DEPTH = 16;
    localparam int TIMEOUT    = 64;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              s_valid = 1'b0;
    logic              s_ready;
    logic [DATA_W-1:0] s_data = '0;
    logic              start = 1'b0;
    logic              valid_out;
    logic [DATA_W-1:0] data_out;
    logic              mean_valid = 1'b0;
    logic              busy;
    logic              frame_done;
    logic              timeout;
    logic              stalled;

    int tests_run    = 0;
    int tests_failed = 0;

    // Monitor and model state
    int cyc = 0;
    int vcnt, fd_cnt, to_cnt, stall_cnt, stall_bad, push_cnt;
    int first_v, last_v, fd_cyc, to_cyc;
    int gap_ctr = 0, src_gap = 0, mean_delay = 5, mv_cnt = 0;
    bit acc, stall_prev, src_manual = 1'b1, mean_en = 1'b1;
    logic [DATA_W-1:0] src_q[$];
    logic [DATA_W-1:0] out_q[$];

    mean_frame_tx #(
        .DATA_W    (DATA_W),
        .FRAME_LEN (FRAME_LEN),
        .FIFO_DEPTH(FIFO_DEPTH),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .start     (start),
        .valid_out (valid_out),
        .data_out  (data_out),
        .mean_valid(mean_valid),
        .busy      (busy),
        .frame_done(frame_done),
        .timeout   (timeout),
        .stalled   (stalled)
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic clear_stats();
        vcnt = 0; fd_cnt = 0; to_cnt = 0; stall_cnt = 0; stall_bad = 0;
        push_cnt = 0; first_v = -1; last_v = -1; fd_cyc = -1; to_cyc = -1;
        stall_prev = 1'b0; mv_cnt = 0; gap_ctr = 0;
        out_q.delete();
    endtask

    // One clock: sample outputs after the edge, then update source and mean model
    task automatic tick();
        logic [DATA_W-1:0] w;
        acc = s_valid && s_ready && !rst;
        @(posedge clk);
        #1;
        if (valid_out) begin
            if (vcnt == 0) first_v = cyc;
            last_v = cyc;
            vcnt++;
            out_q.push_back(data_out);
            if (mean_en && vcnt == FRAME_LEN) mv_cnt = mean_delay;
        end
        if (frame_done) begin fd_cnt++; fd_cyc = cyc; end
        if (timeout) begin to_cnt++; to_cyc = cyc; end
        if (stall_prev && valid_out) stall_bad++;
        stall_prev = stalled;
        if (stalled) stall_cnt++;
        cyc++;
        @(negedge clk);
        if (!src_manual) begin
            if (acc) begin
                w = src_q.pop_front();
                push_cnt++;
                gap_ctr = src_gap;
            end else if (gap_ctr > 0) begin
                gap_ctr--;
            end
            if (gap_ctr == 0 && src_q.size() > 0) begin
                s_valid = 1'b1;
                s_data  = src_q[0];
            end else begin
                s_valid = 1'b0;
                s_data  = '0;
            end
        end
        mean_valid = 1'b0;
        if (mv_cnt > 0) begin
            mv_cnt--;
            if (mv_cnt == 0) mean_valid = 1'b1;
        end
    endtask

    task automatic start_frame();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic run_until_idle(input int budget, output bit ok);
        int n = 0;
        while (busy && n < budget) begin
            tick();
            n++;
        end
        ok = !busy;
    endtask

    task automatic run_until_vcnt(input int target, input int budget, output bit ok);
        int n = 0;
        while (vcnt < target && n < budget) begin
            tick();
            n++;
        end
        ok = (vcnt >= target);
    endtask

    task automatic fill_src(input int n, input logic [DATA_W-1:0] val);
        for (int i = 0; i < n; i++) src_q.push_back(val);
    endtask

    task automatic test_reset();
        logic [6:0] obs;
        src_manual = 1'b1;
        rst = 1'b1; s_valid = 1'b1; s_data = 16'h1234; start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            obs = {valid_out, busy, frame_done, timeout, stalled, s_ready, (data_out != 0)};
            tests_run++;
            if (obs !== 7'b0000010) begin
                tests_failed++;
                $display("FAIL reset_outputs cycle %0d: got %b expected 0000010", i, obs);
            end
        end
        rst = 1'b0; s_valid = 1'b0; start = 1'b0;
        tick();
        tests_run++;
        if (s_ready !== 1'b1 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_release: s_ready=%b busy=%b expected 1 0", s_ready, busy);
        end
        clear_stats();
        start_frame();
        tests_run++;
        if (busy !== 1'b1 || stalled !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_fifo_empty: busy=%b stalled=%b expected 1 1", busy, stalled);
        end
        tick(); tick();
        tests_run++;
        if (vcnt !== 0 || valid_out !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_no_push: valid count %0d expected 0", vcnt);
        end
        rst = 1'b1; tick(); rst = 1'b0; tick();
        src_manual = 1'b0;
    endtask

    task automatic test_full_frame();
        bit ok;
        int bad = 0, sum = 0;
        logic [DATA_W-1:0] mean;
        clear_stats();
        mean_en = 1'b1; mean_delay = 5;
        fill_src(FRAME_LEN, 16'h4000);
        for (int i = 0; i < 4; i++) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        tests_run++;
        if (busy !== 1'b1 || valid_out !== 1'b0) begin
            tests_failed++;
            $display("FAIL full_start_latency: busy=%b valid_out=%b expected 1 0", busy, valid_out);
        end
        tick();
        tests_run++;
        if (valid_out !== 1'b1 || data_out !== 16'h4000) begin
            tests_failed++;
            $display("FAIL full_first_valid: valid_out=%b data=%h expected 1 4000", valid_out, data_out);
        end
        run_until_idle(4000, ok);
        for (int i = 0; i < out_q.size(); i++) begin
            if (out_q[i] !== 16'h4000) bad++;
            sum += int'($signed(out_q[i]));
        end
        mean = 16'(sum / FRAME_LEN);
        tests_run++;
        if (!ok || vcnt != FRAME_LEN || bad != 0) begin
            tests_failed++;
            $display("FAIL full_count: ok=%b count=%0d bad=%0d expected 1 %0d 0", ok, vcnt, bad, FRAME_LEN);
        end
        tests_run++;
        if (last_v - first_v + 1 != FRAME_LEN || stall_cnt != 0) begin
            tests_failed++;
            $display("FAIL full_throughput: span=%0d stalls=%0d expected %0d 0", last_v - first_v + 1, stall_cnt, FRAME_LEN);
        end
        tests_run++;
        if (mean !== 16'h4000) begin
            tests_failed++;
            $display("FAIL full_mean: got %h expected 4000", mean);
        end
        for (int i = 0; i < 3; i++) tick();
        tests_run++;
        if (fd_cnt != 1 || to_cnt != 0 || fd_cyc - last_v != 5 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL full_done: done=%0d to=%0d delay=%0d busy=%b expected 1 0 5 0", fd_cnt, to_cnt, fd_cyc - last_v, busy);
        end
    endtask

    task automatic test_stalls();
        bit ok;
        int bad = 0;
        clear_stats();
        mean_en = 1'b1; mean_delay = 5; src_gap = 2;
        fill_src(FRAME_LEN, 16'hC000);
        start_frame();
        run_until_idle(8000, ok);
        for (int i = 0; i < out_q.size(); i++) if (out_q[i] !== 16'hC000) bad++;
        tests_run++;
        if (!ok || vcnt != FRAME_LEN || bad != 0 || fd_cnt != 1) begin
            tests_failed++;
            $display("FAIL stall_count: ok=%b count=%0d bad=%0d done=%0d expected 1 %0d 0 1", ok, vcnt, bad, fd_cnt, FRAME_LEN);
        end
        tests_run++;
        if (stall_bad != 0 || stall_cnt < 4000) begin
            tests_failed++;
            $display("FAIL stall_flag: valid_after_stall=%0d stall_cycles=%0d expected 0 >=4000", stall_bad, stall_cnt);
        end
        src_gap = 0;
    endtask

    task automatic test_backpressure();
        bit ok;
        int n = 0, bad = 0;
        clear_stats();
        mean_en = 1'b1; mean_delay = 5;
        for (int i = 1; i <= 20; i++) src_q.push_back(16'(i));
        while (s_ready && n < 40) begin tick(); n++; end
        tests_run++;
        if (s_ready !== 1'b0 || push_cnt != FIFO_DEPTH || s_valid !== 1'b1 || s_data !== 16'h0011) begin
            tests_failed++;
            $display("FAIL bp_full: s_ready=%b pushes=%0d s_data=%h expected 0 16 0011", s_ready, push_cnt, s_data);
        end
        for (int i = 0; i < 3; i++) tick();
        tests_run++;
        if (push_cnt != FIFO_DEPTH || s_data !== 16'h0011 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_hold: pushes=%0d s_data=%h busy=%b expected 16 0011 0", push_cnt, s_data, busy);
        end
        start_frame();
        run_until_vcnt(20, 100, ok);
        for (int i = 0; i < 20 && i < out_q.size(); i++) if (out_q[i] !== 16'(i + 1)) bad++;
        tests_run++;
        if (!ok || bad != 0 || push_cnt != 20) begin
            tests_failed++;
            $display("FAIL bp_order: ok=%b mismatched=%0d pushes=%0d expected 1 0 20", ok, bad, push_cnt);
        end
        fill_src(FRAME_LEN - 20, 16'h0000);
        run_until_idle(4000, ok);
        tests_run++;
        if (!ok || vcnt != FRAME_LEN || fd_cnt != 1) begin
            tests_failed++;
            $display("FAIL bp_frame: count=%0d done=%0d expected %0d 1", vcnt, fd_cnt, FRAME_LEN);
        end
    endtask

    task automatic test_timeout();
        bit ok;
        int bad = 0;
        clear_stats();
        mean_en = 1'b0;
        fill_src(FRAME_LEN, 16'h7FFF);
        start_frame();
        run_until_idle(4000, ok);
        tests_run++;
        if (!ok || vcnt != FRAME_LEN || to_cnt != 1 || fd_cnt != 0 || to_cyc - last_v != TIMEOUT) begin
            tests_failed++;
            $display("FAIL timeout_pulse: count=%0d to=%0d done=%0d delay=%0d expected %0d 1 0 %0d", vcnt, to_cnt, fd_cnt, to_cyc - last_v, FRAME_LEN, TIMEOUT);
        end
        for (int i = 0; i < 3; i++) tick();
        tests_run++;
        if (to_cnt != 1 || timeout !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL timeout_width: to=%0d timeout=%b busy=%b expected 1 0 0", to_cnt, timeout, busy);
        end
        clear_stats();
        mean_en = 1'b1; mean_delay = 5;
        fill_src(FRAME_LEN, 16'h1234);
        start_frame();
        run_until_idle(4000, ok);
        for (int i = 0; i < out_q.size(); i++) if (out_q[i] !== 16'h1234) bad++;
        tests_run++;
        if (!ok || vcnt != FRAME_LEN || bad != 0 || fd_cnt != 1 || to_cnt != 0) begin
            tests_failed++;
            $display("FAIL timeout_restart: count=%0d bad=%0d done=%0d to=%0d expected %0d 0 1 0", vcnt, bad, fd_cnt, to_cnt, FRAME_LEN);
        end
    endtask

    task automatic test_start_and_mean_in_send();
        bit ok;
        clear_stats();
        mean_en = 1'b1; mean_delay = 5;
        fill_src(FRAME_LEN, 16'h2222);
        start_frame();
        run_until_vcnt(300, 1000, ok);
        start_frame();
        run_until_vcnt(600, 1000, ok);
        mv_cnt = 1;
        tick(); tick();
        run_until_vcnt(1000, 1000, ok);
        tests_run++;
        if (!ok || fd_cnt != 0 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL send_mean_ignored: done=%0d busy=%b expected 0 1", fd_cnt, busy);
        end
        run_until_idle(4000, ok);
        for (int i = 0; i < 10; i++) tick();
        tests_run++;
        if (!ok || vcnt != FRAME_LEN || fd_cnt != 1 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL send_start_ignored: count=%0d done=%0d busy=%b expected %0d 1 0", vcnt, fd_cnt, busy, FRAME_LEN);
        end
    endtask

    task automatic test_reset_mid_frame();
        bit ok;
        int bad = 0;
        clear_stats();
        mean_en = 1'b1; mean_delay = 5;
        for (int i = 0; i < FRAME_LEN; i++) src_q.push_back(16'(i));
        start_frame();
        run_until_vcnt(1000, 3000, ok);
        for (int i = 0; i < out_q.size(); i++) if (out_q[i] !== 16'(i)) bad++;
        tests_run++;
        if (!ok || bad != 0) begin
            tests_failed++;
            $display("FAIL midrst_order: ok=%b mismatched=%0d expected 1 0", ok, bad);
        end
        src_q.delete();
        s_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests_run++;
        if (valid_out !== 1'b0 || busy !== 1'b0 || s_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL midrst_drop: valid_out=%b busy=%b s_ready=%b expected 0 0 1", valid_out, busy, s_ready);
        end
        tick();
        start_frame();
        tick(); tick();
        tests_run++;
        if (stalled !== 1'b1 || valid_out !== 1'b0) begin
            tests_failed++;
            $display("FAIL midrst_flush: stalled=%b valid_out=%b expected 1 0", stalled, valid_out);
        end
        rst = 1'b1; tick(); rst = 1'b0; tick();
    endtask

    task automatic test_mean_at_timeout();
        bit ok;
        clear_stats();
        mean_en = 1'b1; mean_delay = TIMEOUT;
        fill_src(FRAME_LEN, 16'h0F0F);
        start_frame();
        run_until_idle(4000, ok);
        for (int i = 0; i < 3; i++) tick();
        tests_run++;
        if (!ok || fd_cnt != 1 || to_cnt != 0 || fd_cyc - last_v != TIMEOUT) begin
            tests_failed++;
            $display("FAIL coincident: done=%0d to=%0d delay=%0d expected 1 0 %0d", fd_cnt, to_cnt, fd_cyc - last_v, TIMEOUT);
        end
        mean_delay = 5;
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_stalls();
        test_backpressure();
        test_timeout();
        test_start_and_mean_in_send();
        test_reset_mid_frame();
        test_mean_at_timeout();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
